// File: rtl/generador_de_frecuencia_multicanal_if.sv
// Load handshake bundle for the multi-channel tone generator.
// The master (melody source) addresses a channel and offers a half-period.
// The slave (generator) answers with listo.
interface generador_de_frecuencia_multicanal_if #(
  parameter int unsigned CANALES    = 2,
  parameter int unsigned ANCHO_TONO = 10,
  parameter int unsigned W_SEL      = (CANALES > 1) ? $clog2(CANALES) : 1
) ();

  logic [W_SEL-1:0]      canal_sel;
  logic [ANCHO_TONO-1:0] tono;
  logic                  modo_inmediato;
  logic                  cargar;
  logic                  listo;

  modport master (
    output canal_sel,
    output tono,
    output modo_inmediato,
    output cargar,
    input  listo
  );

  modport slave (
    input  canal_sel,
    input  tono,
    input  modo_inmediato,
    input  cargar,
    output listo
  );

endinterface

// File: rtl/generador_de_frecuencia_multicanal.sv
// Multi-channel square-wave generator with first-order sigma-delta mixer.
// Each channel holds an applied half-period plus one queued value.
// Queued values are applied only on a falling edge of that channel's wave.
module generador_de_frecuencia_multicanal #(
  parameter int unsigned CANALES    = 2,
  parameter int unsigned ANCHO_TONO = 10
) (
  input  logic                                clk_periodo,
  input  logic                                reset,
  generador_de_frecuencia_multicanal_if.slave bus,
  output logic [CANALES-1:0]                  onda_cuadrada,
  output logic [CANALES-1:0]                  activo,
  output logic                                onda_mezcla
);

  localparam int unsigned W_SEL = (CANALES > 1) ? $clog2(CANALES) : 1;
  // acc stays below CANALES; the sum acc+n needs one extra bit.
  localparam int unsigned W_ACC = $clog2(CANALES) + 1;
  localparam int unsigned W_SUM = W_ACC + 1;

  logic [ANCHO_TONO-1:0] tono_act_q  [CANALES];
  logic [ANCHO_TONO-1:0] tono_act_d  [CANALES];
  logic [ANCHO_TONO-1:0] tono_pend_q [CANALES];
  logic [ANCHO_TONO-1:0] tono_pend_d [CANALES];
  logic [ANCHO_TONO-1:0] contador_q  [CANALES];
  logic [ANCHO_TONO-1:0] contador_d  [CANALES];
  logic [CANALES-1:0]    fase_q, fase_d;
  logic [CANALES-1:0]    pend_q, pend_d;
  logic [W_ACC-1:0]      acc_q, acc_d;
  logic                  mezcla_q, mezcla_d;

  logic                  listo_w;
  logic                  transfer;
  logic [W_SUM-1:0]      n_altos;
  logic [W_SUM-1:0]      suma;

  // Ready only for an in-range channel with an empty queue slot.
  always_comb begin
    listo_w = 1'b0;
    for (int i = 0; i < CANALES; i++) begin
      if (bus.canal_sel == W_SEL'(i)) listo_w = !pend_q[i];
    end
  end

  assign bus.listo = listo_w;
  assign transfer  = bus.cargar && listo_w;

  // Per-channel oscillator and load handling.
  always_comb begin
    fase_d = fase_q;
    pend_d = pend_q;
    for (int i = 0; i < CANALES; i++) begin
      tono_act_d[i]  = tono_act_q[i];
      tono_pend_d[i] = tono_pend_q[i];
      contador_d[i]  = contador_q[i];
    end
    for (int i = 0; i < CANALES; i++) begin
      if (tono_act_q[i] != '0) begin
        if (contador_q[i] == tono_act_q[i] - ANCHO_TONO'(1)) begin
          contador_d[i] = '0;
          fase_d[i]     = ~fase_q[i];
          // Falling edge: safe point to swap in the queued half-period.
          if (fase_q[i] && pend_q[i]) begin
            tono_act_d[i] = tono_pend_q[i];
            pend_d[i]     = 1'b0;
          end
        end else begin
          contador_d[i] = contador_q[i] + ANCHO_TONO'(1);
        end
      end else begin
        contador_d[i] = '0;
        fase_d[i]     = 1'b0;
      end
      // listo guarantees pend_q is clear here, so no clash with the swap above.
      if (transfer && (bus.canal_sel == W_SEL'(i))) begin
        if (bus.modo_inmediato || (tono_act_q[i] == '0)) begin
          tono_act_d[i] = bus.tono;
          contador_d[i] = '0;
          fase_d[i]     = 1'b0;
          pend_d[i]     = 1'b0;
        end else begin
          tono_pend_d[i] = bus.tono;
          pend_d[i]      = 1'b1;
        end
      end
    end
  end

  // Sigma-delta mix: density of ones tracks the fraction of high channels.
  always_comb begin
    n_altos = '0;
    for (int i = 0; i < CANALES; i++) begin
      n_altos = n_altos + W_SUM'(fase_q[i]);
    end
    suma = W_SUM'(acc_q) + n_altos;
    if (suma >= W_SUM'(CANALES)) begin
      mezcla_d = 1'b1;
      acc_d    = W_ACC'(suma - W_SUM'(CANALES));
    end else begin
      mezcla_d = 1'b0;
      acc_d    = W_ACC'(suma);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_periodo) begin
    if (reset) begin
      for (int i = 0; i < CANALES; i++) begin
        tono_act_q[i]  <= '0;
        tono_pend_q[i] <= '0;
        contador_q[i]  <= '0;
      end
      fase_q   <= '0;
      pend_q   <= '0;
      acc_q    <= '0;
      mezcla_q <= 1'b0;
    end else begin
      for (int i = 0; i < CANALES; i++) begin
        tono_act_q[i]  <= tono_act_d[i];
        tono_pend_q[i] <= tono_pend_d[i];
        contador_q[i]  <= contador_d[i];
      end
      fase_q   <= fase_d;
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      mezcla_q <= mezcla_d;
    end
  end

  // Status flags derived from applied half-periods.
  always_comb begin
    for (int i = 0; i < CANALES; i++) begin
      activo[i] = (tono_act_q[i] != '0);
    end
  end

  assign onda_cuadrada = fase_q;
  assign onda_mezcla   = mezcla_q;

endmodule

// File: tb/tb_generador_de_frecuencia_multicanal.sv
// Directed bench for the two-channel configuration of the tone generator.
module tb_generador_de_frecuencia_multicanal;

  localparam int unsigned CANALES    = 2;
  localparam int unsigned ANCHO_TONO = 10;

  logic               clk_periodo;
  logic               reset;
  logic [CANALES-1:0] onda_cuadrada;
  logic [CANALES-1:0] activo;
  logic               onda_mezcla;

  int n_pass;
  int n_total;

  generador_de_frecuencia_multicanal_if #(
    .CANALES   (CANALES),
    .ANCHO_TONO(ANCHO_TONO)
  ) bus ();

  generador_de_frecuencia_multicanal #(
    .CANALES   (CANALES),
    .ANCHO_TONO(ANCHO_TONO)
  ) dut (
    .clk_periodo  (clk_periodo),
    .reset        (reset),
    .bus          (bus),
    .onda_cuadrada(onda_cuadrada),
    .activo       (activo),
    .onda_mezcla  (onda_mezcla)
  );

  initial clk_periodo = 1'b0;
  always #5 clk_periodo = ~clk_periodo;

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk_periodo);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cargar = 1'b1;
    bus.canal_sel = 1'b0;
    bus.tono = 10'd5;
    bus.modo_inmediato = 1'b1;
    tick();
    tick();
    n_total++;
    if (onda_cuadrada !== 2'b00) $display("FAIL reset_onda got %b want 00", onda_cuadrada);
    else n_pass++;
    n_total++;
    if (activo !== 2'b00) $display("FAIL reset_activo got %b want 00", activo);
    else n_pass++;
    n_total++;
    if (onda_mezcla !== 1'b0) $display("FAIL reset_mezcla got %b want 0", onda_mezcla);
    else n_pass++;
    n_total++;
    if (bus.listo !== 1'b1) $display("FAIL reset_listo0 got %b want 1", bus.listo);
    else n_pass++;
    bus.canal_sel = 1'b1;
    #1;
    n_total++;
    if (bus.listo !== 1'b1) $display("FAIL reset_listo1 got %b want 1", bus.listo);
    else n_pass++;
    reset = 1'b0;
    bus.cargar = 1'b0;
    bus.canal_sel = 1'b0;
    tick();
    n_total++;
    if ({activo, onda_cuadrada} !== 4'b0000)
      $display("FAIL post_reset_idle got %b want 0000", {activo, onda_cuadrada});
    else n_pass++;
  endtask

  task automatic test_inmediato();
    logic e;
    bus.canal_sel = 1'b0;
    bus.tono = 10'd3;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    #1;
    n_total++;
    if (bus.listo !== 1'b1) $display("FAIL imm_listo got %b want 1", bus.listo);
    else n_pass++;
    tick();
    bus.cargar = 1'b0;
    for (int j = 0; j < 12; j++) begin
      e = ((j / 3) % 2) == 1;
      n_total++;
      if (onda_cuadrada[0] !== e) $display("FAIL imm_onda j=%0d got %b want %b", j, onda_cuadrada[0], e);
      else n_pass++;
      if (j == 0) begin
        n_total++;
        if (activo !== 2'b01) $display("FAIL imm_activo got %b want 01", activo);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_diferido();
    logic e_onda, e_listo;
    bus.canal_sel = 1'b0;
    bus.tono = 10'd3;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    tick();
    bus.cargar = 1'b0;
    tick();
    tick();
    tick();
    n_total++;
    if (onda_cuadrada[0] !== 1'b1) $display("FAIL def_high_before got %b want 1", onda_cuadrada[0]);
    else n_pass++;
    bus.tono = 10'd5;
    bus.modo_inmediato = 1'b0;
    bus.cargar = 1'b1;
    tick();
    for (int j = 4; j <= 16; j++) begin
      e_onda  = (j >= 4 && j <= 5) || (j >= 11 && j <= 15);
      e_listo = (j >= 6);
      n_total++;
      if (onda_cuadrada[0] !== e_onda)
        $display("FAIL def_onda j=%0d got %b want %b", j, onda_cuadrada[0], e_onda);
      else n_pass++;
      n_total++;
      if (bus.listo !== e_listo) $display("FAIL def_listo j=%0d got %b want %b", j, bus.listo, e_listo);
      else n_pass++;
      // Blocked load attempts, immediate mode included.
      if (j == 4) begin
        bus.tono = 10'd7;
        bus.modo_inmediato = 1'b1;
        bus.cargar = 1'b1;
      end else if (j == 5) begin
        bus.cargar = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_silencio();
    logic e_onda, e_act, e_listo;
    bus.canal_sel = 1'b0;
    bus.tono = 10'd4;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    tick();
    bus.tono = 10'd0;
    bus.modo_inmediato = 1'b0;
    tick();
    bus.cargar = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      e_onda  = (j >= 4 && j <= 7);
      e_act   = (j < 8);
      e_listo = (j >= 8);
      n_total++;
      if (onda_cuadrada[0] !== e_onda)
        $display("FAIL sil_onda j=%0d got %b want %b", j, onda_cuadrada[0], e_onda);
      else n_pass++;
      n_total++;
      if (activo[0] !== e_act) $display("FAIL sil_activo j=%0d got %b want %b", j, activo[0], e_act);
      else n_pass++;
      n_total++;
      if (bus.listo !== e_listo) $display("FAIL sil_listo j=%0d got %b want %b", j, bus.listo, e_listo);
      else n_pass++;
      if (j == 10) begin
        bus.tono = 10'd2;
        bus.modo_inmediato = 1'b0;
        bus.cargar = 1'b1;
      end
      tick();
    end
    bus.cargar = 1'b0;
    n_total++;
    if (activo[0] !== 1'b1) $display("FAIL sil_reload_activo got %b want 1", activo[0]);
    else n_pass++;
    for (int m = 0; m < 5; m++) begin
      e_onda = (m == 2) || (m == 3);
      n_total++;
      if (onda_cuadrada[0] !== e_onda)
        $display("FAIL sil_reload_onda m=%0d got %b want %b", m, onda_cuadrada[0], e_onda);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_mezcla();
    logic e_mez, e_onda;
    // One active channel: half-density output during its high phase.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.canal_sel = 1'b0;
    bus.tono = 10'd4;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    tick();
    bus.cargar = 1'b0;
    for (int j = 0; j < 12; j++) begin
      e_mez  = (j == 6) || (j == 8);
      e_onda = (j >= 4 && j <= 7);
      n_total++;
      if (onda_mezcla !== e_mez) $display("FAIL mez1_mezcla j=%0d got %b want %b", j, onda_mezcla, e_mez);
      else n_pass++;
      n_total++;
      if (onda_cuadrada !== {1'b0, e_onda})
        $display("FAIL mez1_onda j=%0d got %b want %b", j, onda_cuadrada, {1'b0, e_onda});
      else n_pass++;
      tick();
    end
    // Two channels brought into phase: mix follows the common wave.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.canal_sel = 1'b1;
    bus.tono = 10'd4;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    tick();
    bus.cargar = 1'b0;
    for (int j = 0; j < 8; j++) begin
      e_mez = (j == 6);
      n_total++;
      if (onda_mezcla !== e_mez) $display("FAIL mez2_solo j=%0d got %b want %b", j, onda_mezcla, e_mez);
      else n_pass++;
      if (j == 7) begin
        bus.canal_sel = 1'b0;
        bus.cargar = 1'b1;
      end
      tick();
    end
    bus.cargar = 1'b0;
    for (int m = 0; m <= 12; m++) begin
      e_onda = ((m / 4) % 2) == 1;
      e_mez  = (m == 0) ? 1'b1 : (((m - 1) / 4) % 2) == 1;
      n_total++;
      if (onda_cuadrada !== {e_onda, e_onda})
        $display("FAIL mez2_onda m=%0d got %b want %b", m, onda_cuadrada, {e_onda, e_onda});
      else n_pass++;
      n_total++;
      if (onda_mezcla !== e_mez) $display("FAIL mez2_mezcla m=%0d got %b want %b", m, onda_mezcla, e_mez);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_pend();
    bus.canal_sel = 1'b1;
    bus.tono = 10'd3;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    tick();
    bus.tono = 10'd6;
    bus.modo_inmediato = 1'b0;
    tick();
    bus.cargar = 1'b0;
    #1;
    n_total++;
    if (bus.listo !== 1'b0) $display("FAIL rp_pend_listo got %b want 0", bus.listo);
    else n_pass++;
    reset = 1'b1;
    bus.tono = 10'd9;
    bus.modo_inmediato = 1'b1;
    bus.cargar = 1'b1;
    tick();
    n_total++;
    if (bus.listo !== 1'b1) $display("FAIL rp_listo got %b want 1", bus.listo);
    else n_pass++;
    n_total++;
    if ({activo, onda_cuadrada, onda_mezcla} !== 5'b00000)
      $display("FAIL rp_clear got %b want 00000", {activo, onda_cuadrada, onda_mezcla});
    else n_pass++;
    reset = 1'b0;
    bus.cargar = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      n_total++;
      if ({activo, onda_cuadrada, onda_mezcla} !== 5'b00000)
        $display("FAIL rp_quiet j=%0d got %b want 00000", j, {activo, onda_cuadrada, onda_mezcla});
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.cargar = 1'b0;
    bus.canal_sel = 1'b0;
    bus.tono = '0;
    bus.modo_inmediato = 1'b0;
    test_reset();
    test_inmediato();
    test_diferido();
    test_silencio();
    test_mezcla();
    test_reset_pend();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/generador_de_frecuencia_multicanal.md
# generador_de_frecuencia_multicanal

Parametrised multi-channel successor to the single-tone square-wave generator. It runs CANALES independent square-wave oscillators on the system clock. Each oscillator's half-period is loaded through a valid/ready handshake, with glitch-free changeover at the falling edge or an immediate restart. A first-order sigma-delta mixer combines the channels onto one audio pin. It sits between the melody generator(s) and the buzzer output.

## Interface
- CANALES, 2: number of oscillator channels (≥1).
- ANCHO_TONO, 10: width of the half-period value.
- W_SEL, max(1,$clog2(CANALES)): channel-select width (derived).
- clk_periodo  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset domain.
- canal_sel  in  W_SEL  channel addressed by the current load.
- tono  in  ANCHO_TONO  half-period in clk_periodo cycles; 0 = silence.
- modo_inmediato  in  1  qualifies a load: 1 = restart now, 0 = change at next falling edge.
- cargar  in  1  load valid.
- listo  out  1  load ready for canal_sel (combinational from registered state).
- onda_cuadrada  out  CANALES  per-channel square wave, registered.
- activo  out  CANALES  channel has a nonzero applied tono.
- onda_mezcla  out  1  sigma-delta mix of all channels, registered.

## Operation
- Per-channel state:
  - tono_act: applied half-period.
  - tono_pend, pend: queued value and queued flag.
  - contador: ANCHO_TONO bits.
  - fase: drives onda_cuadrada.
- Transfer occurs on an edge where cargar && listo.
- listo = !pend[canal_sel] && canal_sel < CANALES. While listo is 0, loads are blocked, including immediate loads.
- Transfer with modo_inmediato=1, or into a channel with tono_act==0:
  - tono_act<=tono, contador<=0, fase<=0, pend<=0.
- Transfer with modo_inmediato=0 into an active channel:
  - tono_pend<=tono, pend<=1.
  - Oscillation continues unchanged.
- Oscillator running (tono_act≠0):
  - contador increments each cycle.
  - When contador==tono_act−1: contador<=0 and fase toggles.
  - If that toggle is 1→0 (falling edge) and pend is set: tono_act<=tono_pend, pend<=0. The new value therefore starts with a full low half-period.
- Silent channel (tono_act==0): contador=0, fase=0.
- A pending value of 0 silences the channel at its next falling edge.
- activo[i] = (tono_act[i]≠0).
- Output frequency = f_clk/(2·tono). tono=1 toggles every cycle.
- Mixer:
  - n = number of channels with fase=1, computed from current registers.
  - Accumulator acc is $clog2(CANALES)+1 bits, reset 0.
  - Each cycle s=acc+n. If s≥CANALES: onda_mezcla<=1 and acc<=s−CANALES. Otherwise onda_mezcla<=0 and acc<=s.
- Only the addressed channel changes on a transfer. The other channels are unaffected the same cycle.

## Timing
- Reset values: onda_cuadrada=0, activo=0, onda_mezcla=0. All tono_act, tono_pend, contador, fase, pend and acc = 0. listo=1 for valid canal_sel.
- Reset mid-operation: all state cleared on that edge. Pending loads are discarded. A cargar during reset is ignored.
- Immediate transfer at edge k with tono=T:
  - onda_cuadrada low after edges k..k+T−1.
  - High after edge k+T for T cycles.
  - Period 2T.
- Deferred transfer:
  - listo falls after the transfer edge.
  - listo rises after the edge where the falling edge is applied. On that same edge the new tono_act takes effect.
- onda_mezcla lags fase by one cycle.
- canal_sel ≥ CANALES (non-power-of-2 CANALES): listo=0 and nothing is loaded.

## Test plan
- Reset with cargar held high → all outputs 0, listo=1, no channel active after reset is released.
- CANALES=2. Immediate load ch0, tono=3, at edge k → onda_cuadrada[0] is 0 for 3 cycles, then 1 for 3 cycles, period 6. activo=2'b01 from k+1.
- ch0 running at 3. Deferred load tono=5 mid high-phase:
  - listo=0 next cycle.
  - Old high phase completes at length 3.
  - Then low 5 / high 5.
  - listo=1 from the falling-edge cycle.
  - A second cargar while listo=0 is ignored.
- ch0 at 4. Deferred load tono=0 → silent after the next falling edge, activo[0]=0. A later deferred load of 2 applies immediately (silent channel).
- Mixer, CANALES=2. ch0 tono=4, ch1 silent → during ch0 high phase onda_mezcla=0,1,0,1 (one cycle late), 0 during low phase. Both channels tono=4, loaded on the same channel-pair sequence with aligned phase → onda_mezcla equals onda_cuadrada[0] delayed one cycle.
- Sync reset asserted while ch1 has pend=1 → next edge: pend cleared, listo=1, all waves 0. The old tono never appears.
